// File: rtl/seq_frame_extractor_pkg.sv
// Shared types and defaults for the 1101 detector and its frame extractor.
package seq_det_pkg;

    localparam int unsigned SEQ_PAYLOAD_W = 8;
    localparam int unsigned SEQ_OVF_W     = 8;

    // Extractor FSM; EX_PARITY is only reachable with SEQ_FRAME_PARITY_EN.
    typedef enum logic [1:0] {
        EX_HUNT,
        EX_CAPTURE,
        EX_PARITY
    } ext_state_e;

    // Upstream 1101 Moore detector states (hit is high in DET_GOT1101).
    typedef enum logic [2:0] {
        DET_IDLE,
        DET_GOT1,
        DET_GOT11,
        DET_GOT110,
        DET_GOT1101
    } det_state_e;

endpackage

// File: rtl/seq_frame_extractor_shift.sv
// Serial-in/parallel-out payload shifter with shift-enable and clear.
// par_o shows the post-shift view while shifting, so the bit being sampled on
// this edge is already part of the parallel word fed to the output register.
module frame_shift_reg #(
    parameter int unsigned PAYLOAD_W = 8
) (
    input  logic                 clk,
    input  logic                 clr_i,
    input  logic                 shift_en_i,
    input  logic                 din_i,
    output logic [PAYLOAD_W-1:0] par_o
);

    logic [PAYLOAD_W-1:0] sr_q;
    logic [PAYLOAD_W-1:0] sr_d;

    // Next word: shift left, new bit enters at the LSB (first bit ends as MSB).
    always_comb begin
        sr_d = {sr_q[PAYLOAD_W-2:0], din_i};
    end

    // Shift register storage with synchronous clear.
    always_ff @(posedge clk) begin
        if (clr_i) begin
            sr_q <= '0;
        end else if (shift_en_i) begin
            sr_q <= sr_d;
        end
    end

    assign par_o = shift_en_i ? sr_d : sr_q;

endmodule

// File: rtl/seq_frame_extractor.sv
// Frame extractor downstream of the 1101 detector: after each hit, captures
// PAYLOAD_W bits into a frame presented on a valid/ready port, and counts
// frames dropped while the consumer stalls.
// Optional: define SEQ_FRAME_PARITY_EN for a trailing even-parity bit and err.
module seq_frame_extractor
    import seq_det_pkg::*;
#(
    parameter int unsigned PAYLOAD_W = SEQ_PAYLOAD_W,
    parameter int unsigned OVF_W     = SEQ_OVF_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 x,
    input  logic                 hit,
    input  logic                 ready,
    output logic [PAYLOAD_W-1:0] data,
    output logic                 valid,
    output logic                 busy,
    output logic                 err,
    output logic [OVF_W-1:0]     ovf_cnt
);

    localparam int unsigned          CNT_W    = $clog2(PAYLOAD_W + 1);
    localparam logic [CNT_W-1:0]     LAST_IDX = CNT_W'(PAYLOAD_W - 1);

    ext_state_e              state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [PAYLOAD_W-1:0]    data_q;
    logic                    valid_q;
    logic [OVF_W-1:0]        ovf_q;
    logic [PAYLOAD_W-1:0]    frame_w;
    logic                    shift_en;
    logic                    frame_done;
    logic                    can_load;

    assign shift_en = ((state_q == EX_HUNT) && hit) || (state_q == EX_CAPTURE);
    assign can_load = !valid_q || ready;

`ifdef SEQ_FRAME_PARITY_EN
    logic err_q;
    assign frame_done = (state_q == EX_PARITY);
    assign err        = err_q;
`else
    assign frame_done = (state_q == EX_CAPTURE) && (cnt_q == LAST_IDX);
    assign err        = 1'b0;
`endif

    frame_shift_reg #(
        .PAYLOAD_W (PAYLOAD_W)
    ) u_shift (
        .clk        (clk),
        .clr_i      (!rst),
        .shift_en_i (shift_en),
        .din_i      (x),
        .par_o      (frame_w)
    );

    // Capture FSM, bit counter, output handshake registers and overrun counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= EX_HUNT;
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= '0;
`ifdef SEQ_FRAME_PARITY_EN
            err_q   <= 1'b0;
`endif
        end else begin
            if (valid_q && ready) begin
                valid_q <= 1'b0;
            end
            // A completing frame overrides the clear above when it can load.
            if (frame_done) begin
                if (can_load) begin
                    data_q  <= frame_w;
                    valid_q <= 1'b1;
`ifdef SEQ_FRAME_PARITY_EN
                    err_q   <= (^frame_w) ^ x;
`endif
                end else if (ovf_q != '1) begin
                    ovf_q <= ovf_q + OVF_W'(1);
                end
            end
            case (state_q)
                EX_HUNT: begin
                    if (hit) begin
                        cnt_q   <= CNT_W'(1);
                        state_q <= EX_CAPTURE;
                    end
                end
                EX_CAPTURE: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_IDX) begin
`ifdef SEQ_FRAME_PARITY_EN
                        state_q <= EX_PARITY;
`else
                        state_q <= EX_HUNT;
`endif
                    end
                end
                default: begin
                    state_q <= EX_HUNT;
                end
            endcase
        end
    end

    assign data    = data_q;
    assign valid   = valid_q;
    assign busy    = (state_q != EX_HUNT);
    assign ovf_cnt = ovf_q;

endmodule

// File: tb/tb_seq_frame_extractor.sv
// Directed bench for seq_frame_extractor with a frame scoreboard.
// Honours SEQ_FRAME_PARITY_EN to match the DUT build.
module tb_seq_frame_extractor;
    import seq_det_pkg::*;

    localparam int unsigned W  = 8;
    localparam int unsigned OW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          x;
    logic          hit;
    logic          ready;
    logic [W-1:0]  data;
    logic          valid;
    logic          busy;
    logic          err;
    logic [OW-1:0] ovf_cnt;

    typedef struct packed {
        logic [W-1:0] d;
        logic         e;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   n_acc    = 0;
    int   n0;

    seq_frame_extractor #(
        .PAYLOAD_W (W),
        .OVF_W     (OW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .x       (x),
        .hit     (hit),
        .ready   (ready),
        .data    (data),
        .valid   (valid),
        .busy    (busy),
        .err     (err),
        .ovf_cnt (ovf_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Consumer side: every accepted frame must match the oldest expected one.
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst === 1'b1 && valid === 1'b1 && ready === 1'b1) begin
            n_acc++;
            checks++;
            assert (sb.size() > 0) else begin
                failures++;
                $error("FAIL sb_unexpected observed=0x%0h expected=none", data);
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("sb_data", data, e.d);
                chk("sb_err", err, e.e);
            end
        end
    end

    task automatic cyc(input logic xv, input logic hv);
        x   = xv;
        hit = hv;
        @(posedge clk);
        #1;
    endtask

    // Preamble 1101, then payload MSB first; hit on the first payload cycle
    // plus any positions in hmask (detector hits inside the payload).
    task automatic send_frame(input logic [W-1:0] p, input logic [W-1:0] hmask,
                              input logic bad_par, input logic rdy_last,
                              input logic chk_lat, input logic push, input string tag);
        logic [3:0] pre;
        logic       fb;
        logic       fh;
        exp_t       ent;
        pre   = 4'b1101;
        ent.d = p;
`ifdef SEQ_FRAME_PARITY_EN
        ent.e = bad_par;
`else
        ent.e = 1'b0;
`endif
        if (push) sb.push_back(ent);
        for (int i = 3; i >= 0; i--) cyc(pre[i], 1'b0);
        for (int i = W - 1; i >= 1; i--) begin
            cyc(p[i], (i == W - 1) || hmask[i]);
            if (i == W - 1 && chk_lat) chk({tag, "_busy_start"}, busy, 1);
        end
`ifdef SEQ_FRAME_PARITY_EN
        cyc(p[0], hmask[0]);
        fb = (^p) ^ bad_par;
        fh = 1'b0;
`else
        fb = p[0];
        fh = hmask[0];
`endif
        if (rdy_last) ready = 1'b1;
        if (chk_lat) chk({tag, "_pre_valid"}, valid, 0);
        cyc(fb, fh);
        hit = 1'b0;
    endtask

    initial begin
        rst = 1'b0; x = 1'b0; hit = 1'b0; ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_data", data, 0);
        chk("rst_valid", valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_ovf", ovf_cnt, 0);
        rst = 1'b1;
        cyc(0, 0); cyc(0, 0);

        // Basic frame with consumer ready.
        ready = 1'b1;
        send_frame(8'hA5, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, "a5");
        chk("a5_valid", valid, 1);
        chk("a5_data", data, 8'hA5);
        chk("a5_busy_end", busy, 0);
        chk("a5_ovf", ovf_cnt, 0);
        cyc(0, 0);
        chk("a5_valid_fall", valid, 0);
        cyc(0, 0); cyc(0, 0);

        // Payload containing 1101: inner hit must not restart capture.
        n0 = n_acc;
        send_frame(8'hDD, 8'h08, 1'b0, 1'b0, 1'b1, 1'b1, "dd");
        chk("dd_data", data, 8'hDD);
        repeat (12) cyc(0, 0);
        chk("dd_count", n_acc - n0, 1);

        // Stalled consumer: second frame dropped, first held.
        ready = 1'b0;
        send_frame(8'h3C, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, "s3c");
        send_frame(8'hC3, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, "sc3");
        chk("ovr_valid", valid, 1);
        chk("ovr_data", data, 8'h3C);
        chk("ovr_cnt", ovf_cnt, 1);
        ready = 1'b1;
        cyc(0, 0);
        chk("ovr_valid_fall", valid, 0);
        chk("ovr_busy", busy, 0);

        // Frame completes on the very cycle the pending one is accepted.
        ready = 1'b0;
        cyc(0, 0);
        send_frame(8'h96, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, "s96");
        send_frame(8'h69, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, "s69");
        chk("same_valid", valid, 1);
        chk("same_data", data, 8'h69);
        chk("same_ovf", ovf_cnt, 1);
        cyc(0, 0);
        chk("same_valid_fall", valid, 0);

        // Reset in the middle of a capture (on the 4th payload bit).
        cyc(1, 0); cyc(1, 0); cyc(0, 0); cyc(1, 0);
        cyc(1, 1); cyc(1, 0); cyc(1, 0);
        rst = 1'b0;
        cyc(1, 0);
        chk("mid_rst_data", data, 0);
        chk("mid_rst_valid", valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_err", err, 0);
        chk("mid_rst_ovf", ovf_cnt, 0);
        rst = 1'b1;
        cyc(0, 0); cyc(0, 0);
        send_frame(8'h5A, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, "s5a");
        chk("s5a_data", data, 8'h5A);
        cyc(0, 0);
        chk("s5a_valid_fall", valid, 0);
        cyc(0, 0); cyc(0, 0);

`ifdef SEQ_FRAME_PARITY_EN
        // Parity good then bad on the same payload.
        send_frame(8'hA5, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, "par0");
        chk("par0_err", err, 0);
        cyc(0, 0);
        send_frame(8'hA5, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, "par1");
        chk("par1_err", err, 1);
        chk("par1_data", data, 8'hA5);
        cyc(0, 0);
`endif

        repeat (4) cyc(0, 0);
        chk("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_frame_extractor.md
# seq_frame_extractor

Downstream companion to the 1101 Moore sequence detector. It consumes the detector's registered hit pulse and the serial bit stream that drives the detector. After each hit it captures the following PAYLOAD_W bits as one frame and presents the frame on a valid/ready output port. It also counts frames dropped because the consumer stalled.

## Interface
- PAYLOAD_W, 8, payload bits captured per frame (≥2).
- OVF_W, 8, width of saturating overrun counter.
- clk  in  1  rising-edge clock, shared with the detector.
- rst  in  1  reset, synchronous, active-low; clock clk.
- x  in  1  serial bit stream, the same bit fed to the detector.
- hit  in  1  detector output. High for exactly the one cycle the detector sits in its GOT1101 state.
- ready  in  1  consumer accepts data when ready && valid.
- data  out  PAYLOAD_W  captured frame; first captured bit is MSB.
- valid  out  1  data holds an unaccepted frame.
- busy  out  1  capture in progress.
- err  out  1  parity error flag for the frame on data; qualified by valid.
- ovf_cnt  out  OVF_W  dropped-frame count; saturates at all-ones.

## Operation
- FSM states: HUNT, CAPTURE; with SEQ_FRAME_PARITY_EN also PARITY.
- HUNT:
  - If hit=1, sample x as payload bit 0 in the same cycle.
  - Load bit counter to 1 and go to CAPTURE.
  - If PAYLOAD_W would already be complete, it is not (PAYLOAD_W ≥ 2).
- CAPTURE:
  - Shift x in every cycle.
  - hit is ignored in this state, because the payload may itself contain 1101.
  - When the PAYLOAD_W-th bit is sampled, go to PARITY if enabled, otherwise perform the frame-complete action and return to HUNT.
- PARITY:
  - Sample x as the parity bit.
  - Perform the frame-complete action and return to HUNT.
- Frame-complete action:
  - If !valid, or valid && ready in this same cycle: load data, set valid=1, load err.
  - Else (valid && !ready): discard the new frame, keep data, valid and err unchanged, and increment ovf_cnt unless it is saturated.
- Handshake:
  - When valid && ready and no frame completes, clear valid on the next edge.
  - data and err hold stable while valid && !ready.
- busy = (state != HUNT).
- Bit counter width: $clog2(PAYLOAD_W+1); it never wraps.
- Reset (rst=0 at a clock edge), also mid-capture or while valid is pending:
  - state=HUNT, shift register=0, data=0, valid=0, busy=0, err=0, ovf_cnt=0.
  - A partial frame is discarded.

## Timing
- Hit asserted in cycle T: payload bits are sampled at edges T..T+PAYLOAD_W-1.
- Without parity: valid rises after edge T+PAYLOAD_W-1, i.e. it is visible in cycle T+PAYLOAD_W.
- With parity: the parity bit is sampled at edge T+PAYLOAD_W and valid is visible in cycle T+PAYLOAD_W+1.
- The first cycle back in HUNT accepts a new hit. Minimum frame-to-frame spacing is PAYLOAD_W cycles (PAYLOAD_W+1 with parity).
- No combinational path from ready to valid or data. All outputs are registered.

## Configuration
- SEQ_FRAME_PARITY_EN defined:
  - One even-parity bit follows the payload.
  - err = XOR(payload, parity bit), registered with data.
- Not defined:
  - No PARITY state; frames are PAYLOAD_W bits.
  - err is tied to 0.

## Structure
- Package seq_det_pkg holds:
  - the typedef enum for extractor states;
  - the default constants SEQ_PAYLOAD_W=8 and SEQ_OVF_W=8;
  - the detector's state enum, for bench reuse.
- Sub-module frame_shift_reg, parameterised by PAYLOAD_W:
  - serial-in/parallel-out with shift-enable and clear;
  - no output register; the parallel view feeds the load of data.
- The top level keeps the FSM, bit counter, output registers and overrun counter.

## Test plan
- Stream 1101 then 10100101 with ready=1 → hit in cycle T; data=8'hA5, valid high for exactly one cycle at T+8; ovf_cnt=0.
- Payload 11011101 (contains 1101) → exactly one frame 8'hDD. The detector hits inside the payload are ignored and do not restart capture.
- ready=0, two back-to-back frames 8'h3C then 8'hC3 → data stays 8'h3C with valid held; ovf_cnt=1. Raise ready → 8'h3C accepted, valid falls.
- Frame completes in the same cycle the consumer accepts the prior frame (ready=1) → new data loaded, valid stays 1 with no gap, ovf_cnt unchanged.
- rst=0 for one cycle at the 4th payload bit, then stream a fresh 1101 plus 8'h5A → no partial frame output; the next frame is 8'h5A. After the reset edge, all outputs are 0.
- With SEQ_FRAME_PARITY_EN: payload 8'hA5 with parity 0 → err=0; parity 1 → err=1. valid appears one cycle later than without the macro.
